// File: rtl/bit_reverse_reorder.sv
// bit_reverse_reorder: converts a bit-reversed FFT output frame into natural
// bin order using a ping-pong pair of N-entry complex buffers. Samples are
// written at the bit-reversed address and read back sequentially, so
// back-to-back frames stream without stalls.
module bit_reverse_reorder #(
   parameter int N     = 64,
   parameter int WIDTH = 16,
   parameter int LP    = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             idata_en,
   input  logic [WIDTH-1:0] idata_r,
   input  logic [WIDTH-1:0] idata_i,
   output logic             odata_en,
   output logic [WIDTH-1:0] odata_r,
   output logic [WIDTH-1:0] odata_i
);

   localparam int               LOG_N = $clog2(N);
   localparam logic [LOG_N-1:0] LAST  = LOG_N'(N - 1);

   logic [LOG_N-1:0] in_count;
   logic [LOG_N-1:0] rd_count;
   logic [LOG_N-1:0] waddr;
   logic             wbank;
   logic             rbank;
   logic             rd_active;
   logic             frame_done;

   // Two banks of N entries, addressed as {bank, index}.
   logic [WIDTH-1:0] mem_r [2*N];
   logic [WIDTH-1:0] mem_i [2*N];

   // Bit-reversed write address and end-of-frame detect.
   always_comb begin
      waddr      = {<<{in_count}};
      frame_done = idata_en && (in_count == LAST);
   end

   // Write counter, bank selection and read sequencing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_count  <= '0;
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         rd_active <= 1'b0;
         rd_count  <= '0;
      end else begin
         if (idata_en) begin
            in_count <= in_count + 1'b1;
         end else begin
            in_count <= '0;
         end

         // A completing frame takes priority over ending the current read,
         // which is what makes consecutive frames seamless.
         if (frame_done) begin
            rbank     <= wbank;
            wbank     <= ~wbank;
            rd_active <= 1'b1;
            rd_count  <= '0;
         end else if (rd_active) begin
            rd_count <= rd_count + 1'b1;
            if (rd_count == LAST) begin
               rd_active <= 1'b0;
            end
         end
      end
   end

   // Registered output: sequential read of the completed bank.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         odata_en <= 1'b0;
         odata_r  <= '0;
         odata_i  <= '0;
      end else if (rd_active) begin
         odata_en <= 1'b1;
         odata_r  <= mem_r[{rbank, rd_count}];
         odata_i  <= mem_i[{rbank, rd_count}];
      end else begin
         odata_en <= 1'b0;
         if (LP != 0) begin
            odata_r <= '0;
            odata_i <= '0;
         end
      end
   end

   // Buffer write; contents are intentionally not reset.
   always_ff @(posedge clock) begin
      if (idata_en) begin
         mem_r[{wbank, waddr}] <= idata_r;
         mem_i[{wbank, waddr}] <= idata_i;
      end
   end

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Directed testbench for bit_reverse_reorder: an N=64/LP=0 instance and an
// N=8/LP=1 instance share clock and reset.
module tb_bit_reverse_reorder;

   logic        clock = 1'b0;
   logic        reset;

   logic        en64;
   logic [15:0] r64, i64;
   logic        oen64;
   logic [15:0] or64, oi64;

   logic        en8;
   logic [15:0] r8, i8;
   logic        oen8;
   logic [15:0] or8, oi8;

   int n_cmp = 0;
   int n_bad = 0;

   bit_reverse_reorder #(.N(64), .WIDTH(16), .LP(0)) u_dut64 (
      .clock    (clock),
      .reset    (reset),
      .idata_en (en64),
      .idata_r  (r64),
      .idata_i  (i64),
      .odata_en (oen64),
      .odata_r  (or64),
      .odata_i  (oi64)
   );

   bit_reverse_reorder #(.N(8), .WIDTH(16), .LP(1)) u_dut8 (
      .clock    (clock),
      .reset    (reset),
      .idata_en (en8),
      .idata_r  (r8),
      .idata_i  (i8),
      .odata_en (oen8),
      .odata_r  (or8),
      .odata_i  (oi8)
   );

   always #5 clock = ~clock;

   function automatic int rev(input int v, input int bits);
      int r = 0;
      int x = v;
      for (int b = 0; b < bits; b++) begin
         r = (r << 1) | (x & 1);
         x = x >> 1;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives one contiguous 64-sample frame: r = base+k, i = -k or base+k.
   task automatic drive_frame64(input int base, input bit neg_i);
      for (int k = 0; k < 64; k++) begin
         en64 = 1'b1;
         r64  = 16'(base + k);
         i64  = neg_i ? 16'(-k) : 16'(base + k);
         tick();
      end
      en64 = 1'b0;
      r64  = '0;
      i64  = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en64 = 1'b0; r64 = '0; i64 = '0;
      en8  = 1'b0; r8  = '0; i8  = '0;
      tick();
      tick();
      n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL rst_en64 got %b want 0", oen64); end
      n_cmp++; if (or64 !== 16'd0) begin n_bad++; $display("FAIL rst_r64 got %0d want 0", or64); end
      n_cmp++; if (oi64 !== 16'd0) begin n_bad++; $display("FAIL rst_i64 got %0d want 0", oi64); end
      n_cmp++; if (oen8 !== 1'b0) begin n_bad++; $display("FAIL rst_en8 got %b want 0", oen8); end
      n_cmp++; if (or8 !== 16'd0) begin n_bad++; $display("FAIL rst_r8 got %0d want 0", or8); end
      n_cmp++; if (oi8 !== 16'd0) begin n_bad++; $display("FAIL rst_i8 got %0d want 0", oi8); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_index_frame();
      logic [15:0] cap [64];
      int ck_j [5] = '{0, 1, 2, 3, 63};
      int ck_v [5] = '{0, 32, 16, 48, 63};
      int e;
      drive_frame64(0, 1'b1);
      n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL idx_en_early got %b want 0", oen64); end
      for (int j = 0; j < 64; j++) begin
         tick();
         cap[j] = or64;
         e = rev(j, 6);
         n_cmp++; if (oen64 !== 1'b1) begin n_bad++; $display("FAIL idx_en j=%0d got %b want 1", j, oen64); end
         n_cmp++; if (or64 !== 16'(e)) begin n_bad++; $display("FAIL idx_r j=%0d got %0d want %0d", j, or64, e); end
         n_cmp++; if (oi64 !== 16'(-e)) begin n_bad++; $display("FAIL idx_i j=%0d got %h want %h", j, oi64, 16'(-e)); end
      end
      tick();
      n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL idx_en_late got %b want 0", oen64); end
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (cap[ck_j[c]] !== 16'(ck_v[c])) begin
            n_bad++;
            $display("FAIL idx_ckpt j=%0d got %0d want %0d", ck_j[c], cap[ck_j[c]], ck_v[c]);
         end
      end
   endtask

   task automatic test_impulse();
      int e;
      for (int k = 0; k < 64; k++) begin
         en64 = 1'b1;
         r64  = (k == 1) ? 16'd1000 : 16'd0;
         i64  = '0;
         tick();
      end
      en64 = 1'b0;
      r64  = '0;
      for (int j = 0; j < 64; j++) begin
         tick();
         e = (j == 32) ? 1000 : 0;
         n_cmp++; if (oen64 !== 1'b1) begin n_bad++; $display("FAIL imp_en j=%0d got %b want 1", j, oen64); end
         n_cmp++; if (or64 !== 16'(e)) begin n_bad++; $display("FAIL imp_r j=%0d got %0d want %0d", j, or64, e); end
         n_cmp++; if (oi64 !== 16'd0) begin n_bad++; $display("FAIL imp_i j=%0d got %0d want 0", j, oi64); end
      end
      tick();
      n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL imp_en_late got %b want 0", oen64); end
   endtask

   task automatic test_back_to_back();
      int o, e;
      logic [15:0] f2i1 = '0;
      for (int t = 0; t <= 256; t++) begin
         if (t < 192) begin
            en64 = 1'b1;
            r64  = 16'(100 * (t / 64) + (t % 64));
            i64  = 16'(-(100 * (t / 64) + (t % 64)));
         end else begin
            en64 = 1'b0;
            r64  = '0;
            i64  = '0;
         end
         tick();
         if (t >= 64 && t < 256) begin
            o = t - 64;
            e = 100 * (o / 64) + rev(o % 64, 6);
            if (o == 129) f2i1 = or64;
            n_cmp++; if (oen64 !== 1'b1) begin n_bad++; $display("FAIL b2b_en o=%0d got %b want 1", o, oen64); end
            n_cmp++; if (or64 !== 16'(e)) begin n_bad++; $display("FAIL b2b_r o=%0d got %0d want %0d", o, or64, e); end
            n_cmp++; if (oi64 !== 16'(-e)) begin n_bad++; $display("FAIL b2b_i o=%0d got %h want %h", o, oi64, 16'(-e)); end
         end else begin
            n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle t=%0d got %b want 0", t, oen64); end
         end
      end
      n_cmp++; if (f2i1 !== 16'd232) begin n_bad++; $display("FAIL b2b_f2i1 got %0d want 232", f2i1); end
   endtask

   task automatic test_abort();
      int e;
      for (int k = 0; k < 45; k++) begin
         en64 = (k < 40);
         r64  = (k < 40) ? 16'(500 + k) : 16'd0;
         i64  = (k < 40) ? 16'(700 + k) : 16'd0;
         tick();
         n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL abort_en k=%0d got %b want 0", k, oen64); end
      end
      drive_frame64(0, 1'b1);
      n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL abort_en_early got %b want 0", oen64); end
      for (int j = 0; j < 64; j++) begin
         tick();
         e = rev(j, 6);
         n_cmp++; if (oen64 !== 1'b1) begin n_bad++; $display("FAIL abort_oen j=%0d got %b want 1", j, oen64); end
         n_cmp++; if (or64 !== 16'(e)) begin n_bad++; $display("FAIL abort_r j=%0d got %0d want %0d", j, or64, e); end
         n_cmp++; if (oi64 !== 16'(-e)) begin n_bad++; $display("FAIL abort_i j=%0d got %h want %h", j, oi64, 16'(-e)); end
      end
      tick();
      n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL abort_en_late got %b want 0", oen64); end
   endtask

   task automatic test_reset_mid_read();
      int e;
      drive_frame64(300, 1'b0);
      for (int j = 0; j <= 20; j++) begin
         tick();
         e = 300 + rev(j, 6);
         n_cmp++; if (or64 !== 16'(e)) begin n_bad++; $display("FAIL rmid_pre_r j=%0d got %0d want %0d", j, or64, e); end
      end
      reset = 1'b1;
      #1;
      n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL rmid_en got %b want 0", oen64); end
      n_cmp++; if (or64 !== 16'd0) begin n_bad++; $display("FAIL rmid_r got %0d want 0", or64); end
      n_cmp++; if (oi64 !== 16'd0) begin n_bad++; $display("FAIL rmid_i got %0d want 0", oi64); end
      tick();
      reset = 1'b0;
      tick();
      n_cmp++; if (oen64 !== 1'b0) begin n_bad++; $display("FAIL rmid_en_post got %b want 0", oen64); end
      drive_frame64(0, 1'b1);
      for (int j = 0; j < 64; j++) begin
         tick();
         e = rev(j, 6);
         n_cmp++; if (oen64 !== 1'b1) begin n_bad++; $display("FAIL rmid_oen j=%0d got %b want 1", j, oen64); end
         n_cmp++; if (or64 !== 16'(e)) begin n_bad++; $display("FAIL rmid_r j=%0d got %0d want %0d", j, or64, e); end
         n_cmp++; if (oi64 !== 16'(-e)) begin n_bad++; $display("FAIL rmid_i j=%0d got %h want %h", j, oi64, 16'(-e)); end
      end
      tick();
   endtask

   task automatic test_n8_lp();
      int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      int f, p, q, fo, o;
      for (int t = 0; t < 45; t++) begin
         f = t / 11;
         p = t % 11;
         if (f < 3 && p < 8) begin
            en8 = 1'b1;
            r8  = 16'(16 * f + p + 1);
            i8  = 16'(100 + 16 * f + p);
         end else begin
            en8 = 1'b0;
            r8  = 16'hBEEF;
            i8  = 16'hCAFE;
         end
         tick();
         q  = t - 8;
         fo = (t >= 8) ? q / 11 : 3;
         o  = (t >= 8) ? q % 11 : 8;
         if (fo < 3 && o < 8) begin
            n_cmp++; if (oen8 !== 1'b1) begin n_bad++; $display("FAIL n8_en t=%0d got %b want 1", t, oen8); end
            n_cmp++; if (or8 !== 16'(16 * fo + ord[o] + 1)) begin n_bad++; $display("FAIL n8_r t=%0d got %0d want %0d", t, or8, 16 * fo + ord[o] + 1); end
            n_cmp++; if (oi8 !== 16'(100 + 16 * fo + ord[o])) begin n_bad++; $display("FAIL n8_i t=%0d got %0d want %0d", t, oi8, 100 + 16 * fo + ord[o]); end
         end else begin
            n_cmp++; if (oen8 !== 1'b0) begin n_bad++; $display("FAIL n8_idle_en t=%0d got %b want 0", t, oen8); end
            n_cmp++; if (or8 !== 16'd0) begin n_bad++; $display("FAIL n8_lp_r t=%0d got %0d want 0", t, or8); end
            n_cmp++; if (oi8 !== 16'd0) begin n_bad++; $display("FAIL n8_lp_i t=%0d got %0d want 0", t, oi8); end
         end
      end
      en8 = 1'b0;
      r8  = '0;
      i8  = '0;
   endtask

   initial begin
      test_reset();
      test_index_frame();
      test_impulse();
      test_back_to_back();
      test_abort();
      test_reset_mid_read();
      test_n8_lp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
